// File: rtl/timer_pkg.sv
// timer_pkg: shared register offsets, TCR field indices
// and APB responder FSM states for periph_timer.
package timer_pkg;

  localparam logic [2:0] TCR_OFS  = 3'd0;
  localparam logic [2:0] TPSC_OFS = 3'd1;
  localparam logic [2:0] TARR_OFS = 3'd2;
  localparam logic [2:0] TCNT_OFS = 3'd3;
  localparam logic [2:0] TSR_OFS  = 3'd4;

  localparam int TCR_EN     = 0;
  localparam int TCR_CLR    = 1;
  localparam int TCR_IRQ_EN = 2;
  localparam int TSR_OVF    = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_t;

endpackage

// File: rtl/timer_core.sv
// timer_core: prescaler, auto-reload counter and
// overflow flag with set-over-clear priority.
module timer_core #(
  parameter int WIDTH = 32,
  parameter int PSC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PSC_W-1:0] i_psc,
  input  logic [WIDTH-1:0] i_arr,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_ovf
);

  logic [PSC_W-1:0] r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             w_tick;
  logic             w_wrap;

  assign w_tick = i_en && (r_pre == i_psc);
  // >= so a lowered TARR still wraps
  assign w_wrap = w_tick && (r_cnt >= i_arr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_pre >= i_psc)
        r_pre <= '0;
      else
        r_pre <= r_pre + PSC_W'(1);
      if (w_tick)
        r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ovf <= 1'b0;
    else if (w_wrap && !i_clr)
      r_ovf <= 1'b1;
    else if (i_ovf_clr)
      r_ovf <= 1'b0;
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/periph_timer.sv
// periph_timer: APB responder timer with prescaler,
// auto-reload, overflow flag and registered irq.
module periph_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PSC_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  apb_state_t       r_state;
  apb_state_t       w_state_nxt;
  logic             w_access;
  logic             w_load;
  logic             w_commit;
  logic [2:0]       w_ofs;
  logic             r_en;
  logic             r_irq_en;
  logic [PSC_W-1:0] r_tpsc;
  logic [WIDTH-1:0] r_tarr;
  logic [WIDTH-1:0] w_cnt;
  logic             w_ovf;
  logic             w_wr_tcr;
  logic             w_clr;
  logic             w_ovf_clr;
  logic [31:0]      w_rdata;
  logic [31:0]      r_prdata;
  logic             r_pready;
  logic             r_irq;
  logic             w_unused;

  assign w_access = PSEL && PENABLE;
  assign w_ofs    = PADDR[4:2];
  assign w_unused = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: if (w_access) w_state_nxt = WAIT;
      WAIT: begin
        if (w_access) begin
          w_state_nxt = RESP;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_commit    = PWRITE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr_tcr  = w_commit && (w_ofs == TCR_OFS);
  assign w_clr     = w_wr_tcr && PWDATA[TCR_CLR];
  assign w_ovf_clr = w_commit && (w_ofs == TSR_OFS)
                     && PWDATA[TSR_OVF];

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_tpsc   <= '0;
      r_tarr   <= '1;
    end else if (w_commit) begin
      if (w_ofs == TCR_OFS) begin
        r_en     <= PWDATA[TCR_EN];
        r_irq_en <= PWDATA[TCR_IRQ_EN];
      end
      if (w_ofs == TPSC_OFS)
        r_tpsc <= PWDATA[PSC_W-1:0];
      if (w_ofs == TARR_OFS)
        r_tarr <= PWDATA[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      TCR_OFS: begin
        w_rdata[TCR_EN]     = r_en;
        w_rdata[TCR_IRQ_EN] = r_irq_en;
      end
      TPSC_OFS: w_rdata = 32'(r_tpsc);
      TARR_OFS: w_rdata = 32'(r_tarr);
      TCNT_OFS: w_rdata = 32'(w_cnt);
      TSR_OFS:  w_rdata[TSR_OVF] = w_ovf;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_prdata <= '0;
      r_pready <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_load)
        r_prdata <= w_rdata;
      r_pready <= w_load;
      r_irq    <= w_ovf && r_irq_en;
    end
  end

  timer_core #(
    .WIDTH(WIDTH),
    .PSC_W(PSC_W)
  ) u_core (
    .i_clk    (PCLK),
    .i_rst_n  (PRESET),
    .i_en     (r_en),
    .i_clr    (w_clr),
    .i_psc    (r_tpsc),
    .i_arr    (r_tarr),
    .i_ovf_clr(w_ovf_clr),
    .o_cnt    (w_cnt),
    .o_ovf    (w_ovf)
  );

  assign PRDATA = r_prdata;
  assign PREADY = r_pready;
  assign irq    = r_irq;

endmodule
